// File: rtl/arb_tree_encoder.sv
// arb_tree_encoder
//   Round-robin arbiter that holds a single grant until released and
//   presents the winner both as a binary index and as a registered OR-tree
//   entry vector consumed by a downstream decode stage.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   req[n-1:0]  : level requests, bit i = requester i
//   rel         : release pulse from the current grant holder
//   grant_valid : high while a grant is held
//   grant_idx   : index of the current holder (0 when no grant)
//   wires_entry : entry vector, 2n-1 bits, all zero when no grant
module arb_tree_encoder #(
  parameter int unsigned n = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n-1:0]         req,
  input  logic                 rel,
  output logic                 grant_valid,
  output logic [$clog2(n)-1:0] grant_idx,
  output logic [2*n-2:0]       wires_entry
);

  localparam int unsigned IW = $clog2(n);
  localparam int unsigned EW = 2 * n - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [EW-1:0]   entry_q, entry_d;

  logic            found;
  logic [IW-1:0]   win;
  int unsigned     cand;

  // Entry vector for winner g: the select bit (entry[0] for g = 0,
  // entry[2g-1] otherwise) plus the pass bit entry[2j-2] of every higher
  // requester j, so the decode chain lets exactly requester g through.
  // The top bit entry[2n-2] is never set.
  function automatic logic [EW-1:0] encode(input logic [IW-1:0] g);
    logic [EW-1:0] e;
    e = '0;
    if (g == '0) e[0] = 1'b1;
    else         e[2*int'(g)-1] = 1'b1;
    for (int unsigned j = 1; j < n; j++) begin
      if (j > int'(g)) e[2*j-2] = 1'b1;
    end
    return e;
  endfunction

  // Round-robin search: first set request bit upward from ptr+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned off = 1; off <= n; off++) begin
      cand = (int'(ptr_q) + off) % n;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          ptr_d   = win;
          idx_d   = win;
          entry_d = encode(win);
        end
      end
      GRANT: begin
        // req is ignored while granted, including on the releasing edge.
        if (rel) begin
          state_d = IDLE;
          idx_d   = '0;
          entry_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        entry_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(n - 1);
      idx_q   <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_idx   = idx_q;
  assign wires_entry = entry_q;

endmodule

// File: tb/tb_arb_tree_encoder.sv
// tb_arb_tree_encoder
//   Directed and randomized checks of arb_tree_encoder with n = 4 against
//   a behavioural round-robin model and a table of expected entry vectors.
module tb_arb_tree_encoder;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         rel;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [6:0]   wires_entry;

  int unsigned n_cmp;
  int unsigned n_fail;

  // Model state
  bit          m_grant;
  int unsigned m_ptr;
  int unsigned m_idx;
  logic [6:0]  entry_tbl [N];

  arb_tree_encoder #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .wires_entry(wires_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode chain as the downstream stage sees it.
  function automatic logic [N-1:0] decode(input logic [6:0] e);
    logic [N-1:0] w;
    for (int unsigned i = 0; i < N; i++) begin
      logic b;
      b = (i == 0) ? e[0] : e[2*i-1];
      for (int unsigned j = i + 1; j < N; j++) b = b & e[2*j-2];
      w[i] = b;
    end
    return w;
  endfunction

  // Advance model by one edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_grant = 0; m_ptr = N - 1; m_idx = 0;
    end else if (!m_grant) begin
      for (int unsigned k = 1; k <= N; k++) begin
        if (!m_grant && req[(m_ptr + k) % N]) begin
          m_grant = 1; m_idx = (m_ptr + k) % N; m_ptr = m_idx;
        end
      end
    end else if (rel) begin
      m_grant = 0; m_idx = 0;
    end
  endtask

  task automatic check_all();
    logic [6:0] exp_e;
    logic [N-1:0] exp_w;
    exp_e = m_grant ? entry_tbl[m_idx] : 7'h00;
    exp_w = m_grant ? (4'b0001 << m_idx) : 4'b0000;
    chk("grant_valid", 32'(grant_valid), 32'(m_grant));
    chk("grant_idx",   32'(grant_idx),   m_idx);
    chk("wires_entry", 32'(wires_entry), 32'(exp_e));
    chk("decode",      32'(decode(wires_entry)), 32'(exp_w));
    chk("entry_top",   32'(wires_entry[6]), 32'd0);
  endtask

  // Apply inputs, clock one edge, then compare just after the edge.
  task automatic step(input logic r, input logic [N-1:0] q, input logic l);
    rst = r; req = q; rel = l;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    entry_tbl[0] = 7'h15; entry_tbl[1] = 7'h16;
    entry_tbl[2] = 7'h18; entry_tbl[3] = 7'h20;
    m_grant = 0; m_ptr = N - 1; m_idx = 0;
    rst = 1; req = '0; rel = 0;
    #2;

    step(1, 4'b0000, 0);                 // reset state
    step(0, 4'b0001, 0);                 // first grant -> 0, 7'h15
    chk("first_idx", 32'(grant_idx), 32'd0);
    chk("first_entry", 32'(wires_entry), 32'h15);
    step(0, 4'b1111, 1);                 // release; req ignored on that edge
    step(0, 4'b1111, 0);                 // -> 1, 7'h16
    chk("rr_1", 32'(wires_entry), 32'h16);
    step(0, 4'b1111, 1);
    step(0, 4'b1111, 0);                 // -> 2, 7'h18
    chk("rr_2", 32'(wires_entry), 32'h18);
    step(0, 4'b1000, 0);                 // req changes while granted
    step(0, 4'b1000, 0);
    chk("hold_2", 32'(grant_idx), 32'd2);
    step(0, 4'b1111, 1);
    step(0, 4'b1111, 0);                 // -> 3, 7'h20
    chk("rr_3", 32'(wires_entry), 32'h20);
    step(0, 4'b1111, 1);
    step(0, 4'b1111, 0);                 // wrap -> 0
    chk("rr_wrap", 32'(grant_idx), 32'd0);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);                 // rel in IDLE ignored
    step(0, 4'b0000, 0);
    chk("idle_rel", 32'(grant_valid), 32'd0);
    step(0, 4'b1000, 0);                 // grant 3
    step(1, 4'b1000, 0);                 // reset mid-grant
    chk("rst_mid", 32'(wires_entry), 32'h00);
    step(0, 4'b1000, 0);                 // ptr = 3, wraps to find 3
    chk("post_rst", 32'(grant_idx), 32'd3);

    for (int unsigned c = 0; c < 400; c++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_tree_encoder.md
ARB_TREE_ENCODER -- requirements
Module: arb_tree_encoder

Interface
REQ-001 Parameter: n, default 32, number of requesters (n >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  n  level request per requester; bit i = requester i.
REQ-005 Port: rel  input  1  release pulse from current grant holder.
REQ-006 Port: grant_valid  output  1  high while a grant is held.
REQ-007 Port: grant_idx  output  $clog2(n)  index of current grant holder.
REQ-008 Port: wires_entry  output  2n-1  registered OR-tree entry vector for the arbiter decode stage.

Function
REQ-009 FSM states IDLE and GRANT; the block SHALL be in IDLE after reset.
REQ-010 IDLE, req == 0: stay IDLE; outputs hold their reset values.
REQ-011 IDLE, req != 0 at edge t: select winner g, enter GRANT; grant_valid, grant_idx = g and wires_entry SHALL be valid from edge t (1-cycle latency from sampled req).
REQ-012 Winner selection SHALL be round-robin: first set req bit found searching upward from ptr+1, modulo n, wrapping n-1 -> 0.
REQ-013 ptr SHALL update to g on the edge entering GRANT; ptr reset value is n-1, so requester 0 has first priority.
REQ-014 GRANT: grant_idx and wires_entry SHALL stay stable regardless of req changes, including deassertion of req[g].
REQ-015 GRANT, rel == 1 at an edge: return to IDLE; grant_valid = 0 and wires_entry = 0 SHALL follow on that edge; there is no back-to-back grant without an IDLE cycle.
REQ-016 rel in IDLE SHALL be ignored.
REQ-017 Encoding for g >= 1: wires_entry[2g-1] = 1; wires_entry[2j-2] = 1 for every j in g+1..n-1; all other bits 0.
REQ-018 Encoding for g = 0: wires_entry[0] = 1; wires_entry[2j-2] = 1 for every j in 2..n-1; all other bits 0.
REQ-019 wires_entry[2n-2] SHALL always be 0.
REQ-020 In IDLE, wires_entry SHALL be all zeros, so the decode stage yields no grant.
REQ-021 When wires_entry is decoded by the arbiter decode chain (wires[i] = entry[2i-1] AND all pass bits entry[2j-2] for j > i; wires[0] = entry[0] AND pass chain), exactly one output bit, bit g, SHALL be 1.
REQ-022 grant_idx SHALL be 0 whenever grant_valid = 0.
REQ-023 req bit changes in the same cycle as rel SHALL be ignored; the next arbitration samples req in the following IDLE cycle.

Reset
REQ-024 rst = 1 at an edge SHALL force IDLE, grant_valid = 0, grant_idx = 0, wires_entry = 0 and ptr = n-1, taking priority over req and rel.
REQ-025 rst asserted mid-grant SHALL drop the grant on that edge without waiting for rel.
REQ-026 The first arbitration after rst deasserts SHALL follow REQ-011 from ptr = n-1.

Verification (n = 4, wires_entry 7 bits)
REQ-027 Reset, then req = 4'b0001 -> next edge: grant_valid = 1, grant_idx = 0, wires_entry = 7'h15.
REQ-028 From ptr = 0, req = 4'b1111 -> grant_idx = 1, wires_entry = 7'h16; after rel then IDLE -> grant_idx = 2, wires_entry = 7'h18; then grant_idx = 3, wires_entry = 7'h20; then wrap to grant_idx = 0.
REQ-029 In GRANT to 2, drop req[2] and raise req[3] -> grant_idx stays 2 and wires_entry stays 7'h18 until rel.
REQ-030 rel pulse while IDLE with req = 0 -> no state change; all outputs stay 0.
REQ-031 rst pulse during GRANT to 3 -> all outputs 0 on that edge; then req = 4'b1000 -> grant_idx = 3, since ptr was reset to 3 and the search wraps to 0 and finds only bit 3.
REQ-032 Scoreboard on every cycle: a decode model of wires_entry SHALL yield one-hot grant_idx when grant_valid = 1 and zero otherwise; wires_entry[6] = 0 always.
